// File: rtl/calc1_port_scheduler.sv
// Round-robin front end sharing one calc1 ALU between NPORT requester ports.
// Each port runs its own capture/issue/wait FSM; a single issue register feeds the unit.

module calc1_port_fsm (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  i_cmd,
    input  logic [31:0] i_data,
    input  logic        i_load,
    input  logic        i_hs,
    input  logic        i_hit,
    input  logic [1:0]  i_resp,
    input  logic [31:0] i_rdata,
    output logic        o_pend,
    output logic        o_busy,
    output logic [3:0]  o_cmd,
    output logic [31:0] o_op1,
    output logic [31:0] o_op2,
    output logic [1:0]  o_resp,
    output logic [31:0] o_data
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARG2,
        S_PEND,
        S_ISSUED,
        S_BUSY
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cmd;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [1:0]  r_resp;
    logic [31:0] r_data;
    logic        w_cmd_ok;
    logic        w_lat_cmd;
    logic        w_lat_op2;
    logic [1:0]  w_resp_nxt;
    logic [31:0] w_data_nxt;

    assign w_cmd_ok = (r_cmd == 4'd1) || (r_cmd == 4'd2) ||
                      (r_cmd == 4'd5) || (r_cmd == 4'd6);

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lat_cmd   = 1'b0;
        w_lat_op2   = 1'b0;
        w_resp_nxt  = 2'd0;
        w_data_nxt  = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (i_cmd != 4'd0) begin
                    w_lat_cmd   = 1'b1;
                    w_state_nxt = S_ARG2;
                end
            end
            S_ARG2: begin
                w_lat_op2 = 1'b1;
                if (w_cmd_ok) begin
                    w_state_nxt = S_PEND;
                end else begin
                    // unsupported command: reject locally, never reaches the unit
                    w_resp_nxt  = 2'd2;
                    w_state_nxt = S_IDLE;
                end
            end
            S_PEND: begin
                if (i_load) w_state_nxt = S_ISSUED;
            end
            S_ISSUED: begin
                if (i_hs) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (i_hit) begin
                    w_resp_nxt  = i_resp;
                    w_data_nxt  = i_rdata;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_cmd  <= 4'd0;
            r_op1  <= 32'd0;
            r_op2  <= 32'd0;
            r_resp <= 2'd0;
            r_data <= 32'd0;
        end else begin
            if (w_lat_cmd) begin
                r_cmd <= i_cmd;
                r_op1 <= i_data;
            end
            if (w_lat_op2) r_op2 <= i_data;
            r_resp <= w_resp_nxt;
            r_data <= w_data_nxt;
        end
    end

    assign o_pend = (r_state == S_PEND);
    assign o_busy = (r_state == S_BUSY);
    assign o_cmd  = r_cmd;
    assign o_op1  = r_op1;
    assign o_op2  = r_op2;
    assign o_resp = r_resp;
    assign o_data = r_data;
endmodule

module calc1_port_scheduler #(
    parameter int NPORT = 4
) (
    input  logic                  c_clk,
    input  logic                  reset,
    input  logic [4*NPORT-1:0]    req_cmd_in,
    input  logic [32*NPORT-1:0]   req_data_in,
    output logic [2*NPORT-1:0]    out_resp,
    output logic [32*NPORT-1:0]   out_data,
    output logic                  alu_valid,
    output logic [3:0]            alu_cmd,
    output logic [31:0]           alu_op1,
    output logic [31:0]           alu_op2,
    output logic [1:0]            alu_tag,
    input  logic                  alu_ready,
    input  logic                  alu_rvalid,
    input  logic [1:0]            alu_rtag,
    input  logic [1:0]            alu_resp,
    input  logic [31:0]           alu_rdata,
    output logic                  protocol_err
);
    logic [NPORT-1:0]        w_pend;
    logic [NPORT-1:0]        w_busy;
    logic [NPORT-1:0]        w_load;
    logic [NPORT-1:0][3:0]   w_cmd;
    logic [NPORT-1:0][31:0]  w_op1;
    logic [NPORT-1:0][31:0]  w_op2;

    logic        r_valid;
    logic [3:0]  r_cmd;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [1:0]  r_tag;
    logic [1:0]  r_last;
    logic        r_perr;

    logic        w_hs;
    logic        w_found;
    logic [1:0]  w_win;
    logic [1:0]  w_k;
    logic        w_issue;

    genvar g;
    generate
        for (g = 0; g < NPORT; g++) begin : g_port
            localparam logic [1:0] TAG = 2'(g);
            calc1_port_fsm u_port (
                .c_clk   (c_clk),
                .reset   (reset),
                .i_cmd   (req_cmd_in[4*g +: 4]),
                .i_data  (req_data_in[32*g +: 32]),
                .i_load  (w_load[g]),
                .i_hs    (w_hs),
                .i_hit   (alu_rvalid && (alu_rtag == TAG)),
                .i_resp  (alu_resp),
                .i_rdata (alu_rdata),
                .o_pend  (w_pend[g]),
                .o_busy  (w_busy[g]),
                .o_cmd   (w_cmd[g]),
                .o_op1   (w_op1[g]),
                .o_op2   (w_op2[g]),
                .o_resp  (out_resp[2*g +: 2]),
                .o_data  (out_data[32*g +: 32])
            );
            assign w_load[g] = w_issue && (w_win == TAG);
        end
    endgenerate

    assign w_hs = r_valid && alu_ready;

    // search starts just past the last winner so every pending port gets a turn
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_k     = 2'd0;
        for (int i = 1; i <= NPORT; i++) begin
            w_k = 2'((int'(r_last) + i) % NPORT);
            if (!w_found && w_pend[w_k]) begin
                w_found = 1'b1;
                w_win   = w_k;
            end
        end
    end

    assign w_issue = (!r_valid || w_hs) && w_found;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_cmd   <= 4'd0;
            r_op1   <= 32'd0;
            r_op2   <= 32'd0;
            r_tag   <= 2'd0;
            r_last  <= 2'(NPORT - 1);
            r_perr  <= 1'b0;
        end else begin
            if (w_issue) begin
                r_valid <= 1'b1;
                r_cmd   <= w_cmd[w_win];
                r_op1   <= w_op1[w_win];
                r_op2   <= w_op2[w_win];
                r_tag   <= w_win;
                r_last  <= w_win;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            // a result for a port that is not waiting is dropped but remembered
            if (alu_rvalid && !w_busy[alu_rtag]) r_perr <= 1'b1;
        end
    end

    assign alu_valid    = r_valid;
    assign alu_cmd      = r_cmd;
    assign alu_op1      = r_op1;
    assign alu_op2      = r_op2;
    assign alu_tag      = r_tag;
    assign protocol_err = r_perr;
endmodule

// File: tb/tb_calc1_port_scheduler.sv
// Directed bench for calc1_port_scheduler: cycle vector table plus hand sequences.
module tb_calc1_port_scheduler;
    logic         c_clk = 1'b0;
    logic         reset;
    logic [15:0]  req_cmd_in;
    logic [127:0] req_data_in;
    logic [7:0]   out_resp;
    logic [127:0] out_data;
    logic         alu_valid;
    logic [3:0]   alu_cmd;
    logic [31:0]  alu_op1, alu_op2;
    logic [1:0]   alu_tag;
    logic         alu_ready, alu_rvalid;
    logic [1:0]   alu_rtag, alu_resp;
    logic [31:0]  alu_rdata;
    logic         protocol_err;

    always #5 c_clk = ~c_clk;

    calc1_port_scheduler #(.NPORT(4)) dut (
        .c_clk(c_clk), .reset(reset),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .out_resp(out_resp), .out_data(out_data),
        .alu_valid(alu_valid), .alu_cmd(alu_cmd), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_tag(alu_tag), .alu_ready(alu_ready), .alu_rvalid(alu_rvalid),
        .alu_rtag(alu_rtag), .alu_resp(alu_resp), .alu_rdata(alu_rdata),
        .protocol_err(protocol_err)
    );

    typedef struct {
        logic [15:0]  cmd;
        logic [127:0] data;
        logic         rdy;
        logic         rv;
        logic [1:0]   rtag;
        logic [1:0]   rresp;
        logic [31:0]  rdata;
        logic [7:0]   e_resp;
        logic [127:0] e_data;
        logic         e_vld;
        logic [1:0]   e_tag;
        logic [3:0]   e_cmd;
        logic [31:0]  e_op1;
        logic [31:0]  e_op2;
    } vec_t;

    vec_t tbl [9];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic clr();
        req_cmd_in  = '0;
        req_data_in = '0;
        alu_ready   = 1'b0;
        alu_rvalid  = 1'b0;
        alu_rtag    = 2'd0;
        alu_resp    = 2'd0;
        alu_rdata   = 32'd0;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    int ph [3];
    int hs_cnt, p3_idx, p3_cnt;
    logic ret_v, hs;
    logic [1:0] ret_t, htag;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // single ADD on port 1, then invalid cmd 3 on port 2
        tbl[0] = '{16'h0001, 128'hFFFF0000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{16'h0000, 128'h0000FFFF, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{16'h0000, 128'h0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 2'd0, 4'd1, 32'hFFFF0000, 32'h0000FFFF};
        tbl[3] = '{16'h0000, 128'h0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{16'h0000, 128'h0, 0, 1, 2'd0, 2'd1, 32'hFFFFFFFF, 8'h01, 128'hFFFFFFFF, 0, 0, 0, 0, 0};
        tbl[5] = '{16'h0000, 128'h0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{16'h0030, 128'h00000123_00000000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0};
        tbl[7] = '{16'h0000, 128'h00000456_00000000, 0, 0, 0, 0, 0, 8'h08, 0, 0, 0, 0, 0, 0};
        tbl[8] = '{16'h0000, 128'h0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0};

        do_reset();
        chk("rst_resp", 128'(out_resp), 128'(0));
        chk("rst_data", out_data, 128'(0));
        chk("rst_valid", 128'(alu_valid), 128'(0));
        chk("rst_perr", 128'(protocol_err), 128'(0));

        for (int i = 0; i < 9; i++) begin
            req_cmd_in  = tbl[i].cmd;
            req_data_in = tbl[i].data;
            alu_ready   = tbl[i].rdy;
            alu_rvalid  = tbl[i].rv;
            alu_rtag    = tbl[i].rtag;
            alu_resp    = tbl[i].rresp;
            alu_rdata   = tbl[i].rdata;
            step();
            chk($sformatf("vec%0d_resp", i), 128'(out_resp), 128'(tbl[i].e_resp));
            chk($sformatf("vec%0d_valid", i), 128'(alu_valid), 128'(tbl[i].e_vld));
            chk($sformatf("vec%0d_perr", i), 128'(protocol_err), 128'(0));
            if (tbl[i].e_vld) begin
                chk($sformatf("vec%0d_tag", i), 128'(alu_tag), 128'(tbl[i].e_tag));
                chk($sformatf("vec%0d_cmd", i), 128'(alu_cmd), 128'(tbl[i].e_cmd));
                chk($sformatf("vec%0d_op1", i), 128'(alu_op1), 128'(tbl[i].e_op1));
                chk($sformatf("vec%0d_op2", i), 128'(alu_op2), 128'(tbl[i].e_op2));
            end
            for (int t = 0; t < 4; t++)
                if (tbl[i].e_resp[2*t +: 2] != 2'd0)
                    chk($sformatf("vec%0d_data_p%0d", i, t + 1),
                        128'(out_data[32*t +: 32]), 128'(tbl[i].e_data[32*t +: 32]));
        end

        // four simultaneous LSH requests, issued in tag order
        do_reset();
        alu_ready   = 1'b1;
        req_cmd_in  = 16'h5555;
        req_data_in = {4{32'h0F0F0F0F}};
        step();
        req_cmd_in  = 16'h0;
        req_data_in = {4{32'h4}};
        step();
        req_data_in = '0;
        for (int t = 0; t < 4; t++) begin
            step();
            chk($sformatf("rr_valid%0d", t), 128'(alu_valid), 128'(1));
            chk($sformatf("rr_tag%0d", t), 128'(alu_tag), 128'(t));
            chk($sformatf("rr_op1_%0d", t), 128'(alu_op1), 128'(32'h0F0F0F0F));
        end
        step();
        chk("rr_drop_valid", 128'(alu_valid), 128'(0));
        alu_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            alu_rvalid = 1'b1;
            alu_rtag   = 2'(t);
            alu_resp   = 2'd1;
            alu_rdata  = 32'h0F0F0F0F << 4;
            step();
            chk($sformatf("rr_resp_p%0d", t + 1), 128'(out_resp), 128'(8'h01 << (2*t)));
            chk($sformatf("rr_data_p%0d", t + 1), 128'(out_data[32*t +: 32]), 128'(32'hF0F0F0F0));
        end
        alu_rvalid = 1'b0;
        step();
        chk("rr_resp_end", 128'(out_resp), 128'(0));

        // fairness: ports 1,2 keep re-requesting, port 3 asks once, ready toggles
        clr();
        for (int p = 0; p < 3; p++) ph[p] = 0;
        ret_v = 1'b0; ret_t = 2'd0;
        hs_cnt = 0; p3_idx = 0; p3_cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            alu_ready  = ((cyc % 2) == 1);
            alu_rvalid = ret_v;
            alu_rtag   = ret_t;
            alu_resp   = 2'd1;
            alu_rdata  = 32'hA0000000 | 32'(ret_t);
            for (int p = 0; p < 3; p++) begin
                req_cmd_in[4*p +: 4]   = (ph[p] == 0) ? 4'd1 : 4'd0;
                req_data_in[32*p +: 32] = 32'(p + 1);
            end
            hs   = alu_valid && alu_ready;
            htag = alu_tag;
            if (hs) begin
                hs_cnt++;
                if (htag == 2'd2 && p3_idx == 0) p3_idx = hs_cnt;
            end
            step();
            ret_v = hs;
            ret_t = htag;
            for (int p = 0; p < 3; p++) begin
                if (ph[p] == 0) ph[p] = 1;
                else if (ph[p] == 1) ph[p] = 2;
                else if (out_resp[2*p +: 2] != 2'd0) begin
                    if (p < 2) ph[p] = 0;
                    else begin
                        p3_cnt++;
                        chk("fair_p3_data", 128'(out_data[64 +: 32]), 128'(32'hA0000002));
                    end
                end
            end
        end
        chk("fair_p3_within3", 128'(p3_idx >= 1 && p3_idx <= 3), 128'(1));
        chk("fair_p3_once", 128'(p3_cnt), 128'(1));
        chk("fair_p12_served", 128'(hs_cnt > 6), 128'(1));
        chk("fair_perr", 128'(protocol_err), 128'(0));

        // out-of-order results on ports 1 and 4, then a stray tag
        do_reset();
        alu_ready   = 1'b1;
        req_cmd_in  = 16'h1001;
        req_data_in = {32'h40, 64'h0, 32'h10};
        step();
        req_cmd_in  = 16'h0;
        req_data_in = {32'h4, 64'h0, 32'h1};
        step();
        req_data_in = '0;
        step();
        chk("ooo_tag0", 128'(alu_tag), 128'(0));
        step();
        chk("ooo_tag3", 128'(alu_tag), 128'(3));
        chk("ooo_op1_p4", 128'(alu_op1), 128'(32'h40));
        step();
        chk("ooo_valid_drop", 128'(alu_valid), 128'(0));
        alu_ready  = 1'b0;
        alu_rvalid = 1'b1; alu_resp = 2'd1;
        alu_rtag   = 2'd3; alu_rdata = 32'h44;
        step();
        chk("ooo_resp_p4", 128'(out_resp), 128'(8'h40));
        chk("ooo_data_p4", 128'(out_data[96 +: 32]), 128'(32'h44));
        alu_rtag = 2'd0; alu_rdata = 32'h11;
        step();
        chk("ooo_resp_p1", 128'(out_resp), 128'(8'h01));
        chk("ooo_data_p1", 128'(out_data[0 +: 32]), 128'(32'h11));
        chk("ooo_perr0", 128'(protocol_err), 128'(0));
        alu_rtag = 2'd1; alu_rdata = 32'h99;
        step();
        chk("stray_resp", 128'(out_resp), 128'(0));
        chk("stray_perr", 128'(protocol_err), 128'(1));
        alu_rvalid = 1'b0;
        step();
        chk("stray_perr_sticky", 128'(protocol_err), 128'(1));

        // asynchronous reset while port 3 is BUSY and port 1 sits in the issue register
        do_reset();
        chk("rst2_perr", 128'(protocol_err), 128'(0));
        req_cmd_in  = 16'h0200;
        req_data_in = 128'hFFFF0000 << 64;
        step();
        req_cmd_in  = 16'h0001;
        req_data_in = (128'hFFFF0000 << 64) | 128'h5;
        step();
        req_cmd_in  = 16'h0;
        req_data_in = 128'h6;
        step();
        chk("ar_tag2", 128'(alu_tag), 128'(2));
        chk("ar_cmd2", 128'(alu_cmd), 128'(2));
        alu_ready = 1'b1;
        step();
        chk("ar_valid_p1", 128'(alu_valid), 128'(1));
        chk("ar_tag_p1", 128'(alu_tag), 128'(0));
        alu_ready = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", 128'(alu_valid), 128'(0));
        chk("ar_cmd", 128'(alu_cmd), 128'(0));
        chk("ar_op1", 128'(alu_op1), 128'(0));
        chk("ar_resp", 128'(out_resp), 128'(0));
        step();
        reset = 1'b0;
        clr();
        alu_rvalid = 1'b1; alu_rtag = 2'd2; alu_resp = 2'd1; alu_rdata = 32'h5;
        step();
        chk("ar_late_perr", 128'(protocol_err), 128'(1));
        chk("ar_late_resp", 128'(out_resp), 128'(0));
        alu_rvalid  = 1'b0;
        req_cmd_in  = 16'h0200;
        req_data_in = 128'hFFFF0000 << 64;
        step();
        req_cmd_in  = 16'h0;
        step();
        req_data_in = '0;
        step();
        chk("sub_valid", 128'(alu_valid), 128'(1));
        chk("sub_tag", 128'(alu_tag), 128'(2));
        chk("sub_op2", 128'(alu_op2), 128'(32'hFFFF0000));
        alu_ready = 1'b1;
        step();
        alu_ready = 1'b0;
        alu_rvalid = 1'b1; alu_rtag = 2'd2; alu_resp = 2'd1;
        alu_rdata  = 32'hFFFF0000 - 32'hFFFF0000;
        step();
        chk("sub_resp", 128'(out_resp), 128'(8'h10));
        chk("sub_data", 128'(out_data[64 +: 32]), 128'(0));
        alu_rvalid = 1'b0;
        step();
        chk("sub_resp_end", 128'(out_resp), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
